// File: rtl/mem_move.sv
// Single-channel SRAM-to-SRAM word mover: ascending/descending copy or constant fill,
// with a destination-address delay line matched to the source read latency.
module mem_move #(
    parameter int unsigned WIDTH         = 256,
    parameter int unsigned MAX_MEM_DEPTH = 320,
    parameter int unsigned RD_LAT        = 1,
    localparam int unsigned AW           = $clog2(MAX_MEM_DEPTH),
    localparam int unsigned LW           = $clog2(MAX_MEM_DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_mode,
    input  logic [AW-1:0]    i_src_addr,
    input  logic [AW-1:0]    i_dst_addr,
    input  logic [LW-1:0]    i_len,
    input  logic [WIDTH-1:0] i_fill_data,
    output logic [AW-1:0]    o_mem_in_addr,
    output logic             o_mem_in_en,
    input  logic [WIDTH-1:0] i_mem_in,
    output logic [AW-1:0]    o_mem_out_addr,
    output logic             o_mem_out_en,
    output logic [WIDTH-1:0] o_mem_out,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    localparam int unsigned SW = LW + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_FILL  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] M_ASC  = 2'd0;
    localparam logic [1:0] M_FILL = 2'd1;
    localparam logic [1:0] M_DESC = 2'd2;
    localparam logic [1:0] M_RSVD = 2'd3;

    logic [2:0]       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [AW-1:0]    src_q, src_d, dst_q, dst_d;
    logic [LW-1:0]    len_q, len_d, cnt_q, cnt_d;
    logic [WIDTH-1:0] fill_q, fill_d;
    logic             rd_en_q, rd_en_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic             out_en_q, out_en_d;
    logic [AW-1:0]    out_addr_q, out_addr_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic             dl_v0_d;
    logic [AW-1:0]    dl_a0_d;
    logic [RD_LAT-1:0] dl_v_q;
    logic [AW-1:0]    dl_a_q [RD_LAT];
    logic             start_err;
    logic             desc;

    // Address of word k; descending walks from the top of the region down.
    function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] base,
                                                 input logic [LW-1:0] len,
                                                 input logic [LW-1:0] k,
                                                 input logic          dn);
        logic [SW-1:0] a;
        if (dn) a = SW'(base) + SW'(len) - SW'(k) - SW'(1);
        else    a = SW'(base) + SW'(k);
        return AW'(a);
    endfunction

    assign desc = (mode_q == M_DESC);
    assign start_err = (i_mode == M_RSVD)
                    || ((SW'(i_dst_addr) + SW'(i_len)) > SW'(MAX_MEM_DEPTH))
                    || ((i_mode != M_FILL) && ((SW'(i_src_addr) + SW'(i_len)) > SW'(MAX_MEM_DEPTH)));

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        fill_d     = fill_q;
        cnt_d      = cnt_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = '0;
        dl_v0_d    = 1'b0;
        dl_a0_d    = '0;
        out_en_d   = dl_v_q[RD_LAT-1];
        out_addr_d = dl_v_q[RD_LAT-1] ? dl_a_q[RD_LAT-1] : '0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    mode_d = i_mode;
                    src_d  = i_src_addr;
                    dst_d  = i_dst_addr;
                    len_d  = i_len;
                    fill_d = i_fill_data;
                    err_d  = 1'b0;
                    cnt_d  = LW'(1);
                    if (start_err) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (i_len == LW'(0)) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (i_mode == M_FILL) begin
                        out_en_d   = 1'b1;
                        out_addr_d = word_addr(i_dst_addr, i_len, LW'(0), 1'b0);
                        busy_d     = 1'b1;
                        state_d    = S_FILL;
                    end else begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = word_addr(i_src_addr, i_len, LW'(0), i_mode == M_DESC);
                        dl_v0_d   = 1'b1;
                        dl_a0_d   = word_addr(i_dst_addr, i_len, LW'(0), i_mode == M_DESC);
                        busy_d    = 1'b1;
                        state_d   = S_READ;
                    end
                end
            end
            S_READ: begin
                if (cnt_q < len_q) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = word_addr(src_q, len_q, cnt_q, desc);
                    dl_v0_d   = 1'b1;
                    dl_a0_d   = word_addr(dst_q, len_q, cnt_q, desc);
                    cnt_d     = cnt_q + LW'(1);
                end else begin
                    cnt_d   = LW'(1);
                    state_d = S_DRAIN;
                end
            end
            // Wait for the last RD_LAT reads to come back and be written.
            S_DRAIN: begin
                if (cnt_q == LW'(RD_LAT)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + LW'(1);
                end
            end
            S_FILL: begin
                if (cnt_q < len_q) begin
                    out_en_d   = 1'b1;
                    out_addr_d = word_addr(dst_q, len_q, cnt_q, 1'b0);
                    cnt_d      = cnt_q + LW'(1);
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            mode_q     <= M_ASC;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            fill_q     <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            out_en_q   <= 1'b0;
            out_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            fill_q     <= fill_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            out_en_q   <= out_en_d;
            out_addr_q <= out_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Destination address rides alongside each outstanding read.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dl_v_q <= '0;
            for (int i = 0; i < RD_LAT; i++) dl_a_q[i] <= '0;
        end else begin
            dl_v_q[0] <= dl_v0_d;
            dl_a_q[0] <= dl_a0_d;
            for (int i = 1; i < RD_LAT; i++) begin
                dl_v_q[i] <= dl_v_q[i-1];
                dl_a_q[i] <= dl_a_q[i-1];
            end
        end
    end

    assign o_mem_in_en    = rd_en_q;
    assign o_mem_in_addr  = rd_addr_q;
    assign o_mem_out_en   = out_en_q;
    assign o_mem_out_addr = out_addr_q;
    assign o_mem_out      = out_en_q ? ((mode_q == M_FILL) ? fill_q : i_mem_in) : '0;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_err          = err_q;

endmodule
